// File: rtl/wos_pkg.sv
// rtl/wos_pkg.sv - shared types and width helpers for the weighted-order-statistics filter blocks
package wos_pkg;

    // Control states of the bit-serial rank-select unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } wos_state_e;

    // Bits needed to hold a population count of an n-bit mask (values 0..n).
    function automatic int rank_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to address one bit of an n-bit mask (values 0..n-1).
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bitsum_tree.sv
// rtl/bitsum_tree.sv - combinational population count of an N-bit vector
module bitsum_tree
    import wos_pkg::*;
#(
    parameter int N     = 8,
    parameter int SUM_W = rank_w(N)
) (
    input  logic [N-1:0]     in_bits,
    output logic [SUM_W-1:0] out_sum
);

    // Sum every input bit; the result width covers the all-ones case.
    always_comb begin
        out_sum = '0;
        for (int i = 0; i < N; i++) begin
            out_sum = out_sum + SUM_W'(in_bits[i]);
        end
    end

endmodule

// File: rtl/kth_bit_select.sv
// rtl/kth_bit_select.sv - bit-serial select of the k-th set bit of a threshold mask
module kth_bit_select
    import wos_pkg::*;
#(
    parameter int N      = 7,
    parameter int RANK_W = rank_w(N),
    parameter int IDX_W  = idx_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_mask,
    input  logic [RANK_W-1:0] in_rank,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_found,
    output logic [RANK_W-1:0] out_count
);

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(N - 1);

    wos_state_e state_q, state_d;

    logic [N-1:0]      mask_q,  mask_d;
    logic [RANK_W-1:0] rank_q,  rank_d;
    logic [RANK_W-1:0] count_q, count_d;
    logic              found_q, found_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;

    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
    logic              out_found_q, out_found_d;
    logic [RANK_W-1:0] out_count_q, out_count_d;

    logic accept;
    logic bit_set;
    logic hit;
    logic last_bit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, scan N bits, wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_SCAN;
            ST_SCAN: if (last_bit)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output decode: handshake flags come straight from the state register.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        out_idx   = out_idx_q;
        out_found = out_found_q;
        out_count = out_count_q;
    end

    assign accept   = in_valid && in_ready;
    assign last_bit = (ptr_q == LAST_PTR);
    assign bit_set  = mask_q[ptr_q];
    // The extra MSB keeps count+1 from wrapping when count already equals N.
    assign hit      = bit_set && !found_q &&
                      (({1'b0, count_q} + (RANK_W + 1)'(1)) == {1'b0, rank_q});

    // Datapath next values: one counter, one pointer, one comparator.
    always_comb begin
        mask_d      = mask_q;
        rank_d      = rank_q;
        count_d     = count_q;
        found_d     = found_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        out_idx_d   = out_idx_q;
        out_found_d = out_found_q;
        out_count_d = out_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mask_d  = in_mask;
                    rank_d  = in_rank;
                    count_d = '0;
                    found_d = 1'b0;
                    idx_d   = '0;
                    ptr_d   = '0;
                end
            end
            ST_SCAN: begin
                if (bit_set) begin
                    count_d = count_q + RANK_W'(1);
                end
                if (hit) begin
                    found_d = 1'b1;
                    idx_d   = ptr_q;
                end
                if (last_bit) begin
                    ptr_d       = '0;
                    out_idx_d   = idx_d;
                    out_found_d = found_d;
                    out_count_d = count_d;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and result registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            rank_q      <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            idx_q       <= '0;
            ptr_q       <= '0;
            out_idx_q   <= '0;
            out_found_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            mask_q      <= mask_d;
            rank_q      <= rank_d;
            count_q     <= count_d;
            found_q     <= found_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            out_idx_q   <= out_idx_d;
            out_found_q <= out_found_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_kth_bit_select.sv
// tb/tb_kth_bit_select.sv - directed and sweep bench for kth_bit_select
module tb_kth_bit_select;
    import wos_pkg::*;

    localparam int N      = 7;
    localparam int RANK_W = rank_w(N);
    localparam int IDX_W  = idx_w(N);
    localparam int BT_W   = rank_w(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_mask;
    logic [RANK_W-1:0] in_rank;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_found;
    logic [RANK_W-1:0] out_count;

    logic [N-1:0]      gold_mask;
    logic [BT_W-1:0]   gold_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    kth_bit_select #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_rank   (in_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_found (out_found),
        .out_count (out_count)
    );

    bitsum_tree #(.N(N + 1)) golden (
        .in_bits ({1'b0, gold_mask}),
        .out_sum (gold_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the mask upward and stop at the k-th one.
    task automatic ref_select(input logic [N-1:0] m, input int k,
                              output logic [IDX_W-1:0] idx, output logic f,
                              output logic [RANK_W-1:0] cnt);
        int c;
        c = 0; idx = '0; f = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                c++;
                if (c == k && !f) begin
                    f = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
        cnt = RANK_W'(c);
    endtask

    // Issue one request and collect its result; reports latency, timeout and output stability.
    task automatic run_req(input logic [N-1:0] m, input logic [RANK_W-1:0] k, input bit rand_ready,
                           output int lat, output logic [IDX_W-1:0] idx, output logic f,
                           output logic [RANK_W-1:0] cnt, output bit timeout, output bit unstable);
        int w;
        timeout = 0; unstable = 0; lat = 0;
        idx = '0; f = 1'b0; cnt = '0;
        in_mask = m; in_rank = k; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin step(); w++; end
        if (!in_ready) begin
            timeout = 1; in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin step(); lat++; end
        if (!out_valid) begin
            timeout = 1;
            return;
        end
        idx = out_idx; f = out_found; cnt = out_count;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        w = 0;
        while (!out_ready) begin
            step();
            if (!out_valid || out_idx !== idx || out_found !== f || out_count !== cnt) unstable = 1;
            w++;
            out_ready = (w >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mask = '0; in_rank = '0;
        gold_mask = '0;
        step(); step();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_found !== 1'b0 || out_count !== '0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state got v=%b idx=%0d f=%b cnt=%0d rdy=%b exp v=0 idx=0 f=0 cnt=0 rdy=1",
                     out_valid, out_idx, out_found, out_count, in_ready);
        end
    endtask

    task automatic test_basic();
        int lat; logic [IDX_W-1:0] idx; logic f; logic [RANK_W-1:0] cnt; bit to, un;
        run_req(7'b0101101, 3'd3, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || lat != 8) begin
            tests_failed++; $display("FAIL basic_latency got=%0d timeout=%0d exp=8", lat, to);
        end
        tests_run++;
        if (idx !== 3'd3 || f !== 1'b1 || cnt !== 3'd4) begin
            tests_failed++; $display("FAIL basic_result got idx=%0d f=%b cnt=%0d exp idx=3 f=1 cnt=4", idx, f, cnt);
        end
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_return_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_not_found();
        int lat; logic [IDX_W-1:0] idx; logic f; logic [RANK_W-1:0] cnt; bit to, un;
        run_req(7'b0101101, 3'd0, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || idx !== 3'd0 || f !== 1'b0 || cnt !== 3'd4) begin
            tests_failed++; $display("FAIL k0 got idx=%0d f=%b cnt=%0d to=%0d exp idx=0 f=0 cnt=4", idx, f, cnt, to);
        end
        run_req(7'b0101101, 3'd5, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || idx !== 3'd0 || f !== 1'b0 || cnt !== 3'd4) begin
            tests_failed++; $display("FAIL k5 got idx=%0d f=%b cnt=%0d to=%0d exp idx=0 f=0 cnt=4", idx, f, cnt, to);
        end
    endtask

    task automatic test_extremes();
        int lat; logic [IDX_W-1:0] idx; logic f; logic [RANK_W-1:0] cnt; bit to, un;
        run_req(7'b1111111, 3'd7, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || idx !== 3'd6 || f !== 1'b1 || cnt !== 3'd7) begin
            tests_failed++; $display("FAIL ones_k7 got idx=%0d f=%b cnt=%0d exp idx=6 f=1 cnt=7", idx, f, cnt);
        end
        run_req(7'b1111111, 3'd1, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || idx !== 3'd0 || f !== 1'b1 || cnt !== 3'd7) begin
            tests_failed++; $display("FAIL ones_k1 got idx=%0d f=%b cnt=%0d exp idx=0 f=1 cnt=7", idx, f, cnt);
        end
        run_req(7'b0000000, 3'd1, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || idx !== 3'd0 || f !== 1'b0 || cnt !== 3'd0) begin
            tests_failed++; $display("FAIL zero_k1 got idx=%0d f=%b cnt=%0d exp idx=0 f=0 cnt=0", idx, f, cnt);
        end
    endtask

    task automatic test_backpressure();
        int w; bit bad_rdy, bad_stable, bad_extra;
        bad_rdy = 0; bad_stable = 0; bad_extra = 0;
        in_mask = 7'b0110010; in_rank = 3'd2; in_valid = 1'b1;
        step();
        in_mask = 7'b1111111; in_rank = 3'd1;
        for (int i = 0; i < N; i++) begin
            in_valid = i[0];
            if (in_ready !== 1'b0) bad_rdy = 1;
            step();
        end
        w = 0;
        while (!out_valid && w < 20) begin step(); w++; end
        tests_run++;
        if (!out_valid) begin
            tests_failed++; $display("FAIL bp_done_timeout got v=0 exp v=1");
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            if (in_ready !== 1'b0) bad_rdy = 1;
            if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_found !== 1'b1 || out_count !== 3'd3) bad_stable = 1;
            step();
        end
        tests_run++;
        if (bad_stable || out_idx !== 3'd4 || out_found !== 1'b1 || out_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL bp_stable got idx=%0d f=%b cnt=%0d exp idx=4 f=1 cnt=3", out_idx, out_found, out_count);
        end
        tests_run++;
        if (bad_rdy) begin
            tests_failed++; $display("FAIL bp_in_ready got=high exp=low during SCAN/DONE");
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_return_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        for (int i = 0; i < N + 3; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad_extra = 1;
            step();
        end
        tests_run++;
        if (bad_extra) begin
            tests_failed++; $display("FAIL bp_extra_request got=busy exp=idle");
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic [IDX_W-1:0] idx; logic f; logic [RANK_W-1:0] cnt; bit to, un;
        in_mask = 7'b0000111; in_rank = 3'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_found !== 1'b0 || out_count !== '0) begin
            tests_failed++;
            $display("FAIL midscan_reset_outputs got v=%b idx=%0d f=%b cnt=%0d exp all 0",
                     out_valid, out_idx, out_found, out_count);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midscan_reset_ready got=%b exp=1", in_ready);
        end
        run_req(7'b1000000, 3'd1, 0, lat, idx, f, cnt, to, un);
        tests_run++;
        if (to || lat != 8 || idx !== 3'd6 || f !== 1'b1 || cnt !== 3'd1) begin
            tests_failed++;
            $display("FAIL midscan_new_req got idx=%0d f=%b cnt=%0d lat=%0d exp idx=6 f=1 cnt=1 lat=8", idx, f, cnt, lat);
        end
    endtask

    task automatic test_sweep();
        int lat; logic [IDX_W-1:0] idx; logic f; logic [RANK_W-1:0] cnt; bit to, un;
        logic [IDX_W-1:0] e_idx; logic e_f; logic [RANK_W-1:0] e_cnt;
        logic [N-1:0] m;
        logic [RANK_W-1:0] k;
        for (int mi = 0; mi < (1 << N); mi++) begin
            for (int ki = 0; ki <= N; ki++) begin
                m = N'(mi); k = RANK_W'(ki);
                gold_mask = m;
                ref_select(m, ki, e_idx, e_f, e_cnt);
                run_req(m, k, 1, lat, idx, f, cnt, to, un);
                tests_run++;
                if (to || un || lat != N + 1 || idx !== e_idx || f !== e_f || cnt !== e_cnt) begin
                    tests_failed++;
                    $display("FAIL sweep m=%b k=%0d got idx=%0d f=%b cnt=%0d lat=%0d to=%0d un=%0d exp idx=%0d f=%b cnt=%0d lat=%0d",
                             m, ki, idx, f, cnt, lat, to, un, e_idx, e_f, e_cnt, N + 1);
                end
                tests_run++;
                if (BT_W'(cnt) !== gold_count) begin
                    tests_failed++;
                    $display("FAIL sweep_bitsum m=%b got=%0d exp=%0d", m, cnt, gold_count);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_not_found();
        test_extremes();
        test_backpressure();
        test_reset_mid_scan();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
